// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_pkg
// Brief    : PID classes and transaction-controller states shared by the USB
//            receiver, transmitter, AHB slave and transaction controller.
// Revision : 1.0 - initial release
// ============================================================================
package usb_pkg;

    typedef enum logic [2:0] {
        PID_NONE  = 3'd0,
        PID_OUT   = 3'd1,
        PID_IN    = 3'd2,
        PID_DATA0 = 3'd3,
        PID_DATA1 = 3'd4,
        PID_ACK   = 3'd5,
        PID_NAK   = 3'd6,
        PID_STALL = 3'd7
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_WAIT = 3'd1,
        ST_TURN    = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_TX_BUSY = 3'd4,
        ST_AWAIT   = 3'd5
    } txn_state_t;

    function automatic logic is_data(input pid_t p);
        return (p == PID_DATA0) || (p == PID_DATA1);
    endfunction

    function automatic logic is_handshake(input pid_t p);
        return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module   : flex_counter
// Brief    : Up-counter with synchronous clear that saturates at rollover_val
//            and flags while sitting on that value.
// Revision : 1.0 - initial release
// ============================================================================
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable && (r_count != rollover_val)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign rollover_flag = (r_count == rollover_val);

endmodule
`default_nettype wire

// File: rtl/usb_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_txn_ctrl
// Brief    : Arbitrates the USB TX command between automatic handshakes and
//            software requests, enforcing turnaround and host-reply timeout.
// Revision : 1.0 - initial release
// ============================================================================
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int TURNAROUND_CYCLES = 8,
    parameter int RESP_TIMEOUT      = 64,
    parameter int NAK_THRESH        = 48
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] rx_packet,
    input  logic       rx_data_ready,
    input  logic       rx_transfer_active,
    input  logic       rx_error,
    input  logic [5:0] buffer_occupancy_rx,
    input  logic [2:0] ahb_tx_packet,
    input  logic       ahb_tx_req,
    input  logic       auto_hs_en,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    output logic [2:0] tx_packet,
    output logic       d_mode,
    output logic       ahb_tx_busy,
    output logic       txn_done,
    output logic       txn_timeout,
    output logic       txn_error
);

    localparam int c_max_cycles = (TURNAROUND_CYCLES > RESP_TIMEOUT) ? TURNAROUND_CYCLES : RESP_TIMEOUT;
    localparam int c_cnt_w      = $clog2(c_max_cycles) + 1;
    // Counters stop one short so the command lands exactly N clocks after entry.
    localparam logic [c_cnt_w-1:0] c_turn_last = c_cnt_w'(TURNAROUND_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_resp_last = c_cnt_w'(RESP_TIMEOUT - 1);
    localparam logic [5:0]         c_nak_thresh = 6'(NAK_THRESH);

    txn_state_t r_state, w_state_next;
    pid_t       r_chosen, w_chosen_next;
    logic       r_from_slot, w_from_slot_next;
    logic       r_slot_valid;
    pid_t       r_slot_pid;
    pid_t       r_tx_packet;
    logic       r_d_mode, r_txn_done, r_txn_timeout, r_txn_error;
    logic       w_done, w_timeout, w_error, w_slot_drop, w_slot_release;
    logic       w_turn_last, w_resp_last;
    pid_t       w_rx_pid;

    assign w_rx_pid = pid_t'(rx_packet);

    flex_counter #(.WIDTH(c_cnt_w)) u_turn_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (r_state != ST_TURN),
        .count_enable (r_state == ST_TURN),
        .rollover_val (c_turn_last),
        .rollover_flag(w_turn_last)
    );

    flex_counter #(.WIDTH(c_cnt_w)) u_resp_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (r_state != ST_AWAIT),
        .count_enable (r_state == ST_AWAIT),
        .rollover_val (c_resp_last),
        .rollover_flag(w_resp_last)
    );

    always_comb begin
        w_state_next     = r_state;
        w_chosen_next    = r_chosen;
        w_from_slot_next = r_from_slot;
        w_done           = 1'b0;
        w_timeout        = 1'b0;
        w_error          = 1'b0;
        w_slot_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_transfer_active) begin
                    w_state_next = ST_RX_WAIT;
                end else if (r_slot_valid && is_handshake(r_slot_pid)) begin
                    w_state_next     = ST_TURN;
                    w_chosen_next    = r_slot_pid;
                    w_from_slot_next = 1'b1;
                end else if (r_slot_valid && !is_data(r_slot_pid)) begin
                    // Token classes can never be transmitted; discard them.
                    w_slot_drop = 1'b1;
                end
            end
            ST_RX_WAIT: begin
                if (rx_data_ready) begin
                    w_state_next = ST_IDLE;
                    if (rx_error) begin
                        w_error = 1'b1;
                    end else if (is_data(w_rx_pid)) begin
                        if (auto_hs_en) begin
                            w_state_next     = ST_TURN;
                            w_chosen_next    = (buffer_occupancy_rx > c_nak_thresh) ? PID_NAK : PID_ACK;
                            w_from_slot_next = 1'b0;
                        end
                    end else if (w_rx_pid == PID_IN) begin
                        w_state_next = ST_TURN;
                        if (r_slot_valid && is_data(r_slot_pid)) begin
                            w_chosen_next    = r_slot_pid;
                            w_from_slot_next = 1'b1;
                        end else begin
                            w_chosen_next    = PID_NAK;
                            w_from_slot_next = 1'b0;
                        end
                    end
                end
            end
            ST_TURN: begin
                if (w_turn_last) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tx_transfer_active) begin
                    w_state_next = ST_TX_BUSY;
                end
            end
            ST_TX_BUSY: begin
                if (tx_error) begin
                    w_error      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (!tx_transfer_active) begin
                    if (is_data(r_chosen)) begin
                        w_state_next = ST_AWAIT;
                    end else begin
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_AWAIT: begin
                if (rx_data_ready) begin
                    w_state_next = ST_IDLE;
                    if (!rx_error && (w_rx_pid == PID_ACK)) begin
                        w_done = 1'b1;
                    end else begin
                        w_error = 1'b1;
                    end
                end else if (w_resp_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_slot_release = ((r_state == ST_TURN) && w_turn_last && r_from_slot) || w_slot_drop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= ST_IDLE;
            r_chosen      <= PID_NONE;
            r_from_slot   <= 1'b0;
            r_slot_valid  <= 1'b0;
            r_slot_pid    <= PID_NONE;
            r_tx_packet   <= PID_NONE;
            r_d_mode      <= 1'b0;
            r_txn_done    <= 1'b0;
            r_txn_timeout <= 1'b0;
            r_txn_error   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_chosen      <= w_chosen_next;
            r_from_slot   <= w_from_slot_next;
            r_tx_packet   <= (w_state_next == ST_ISSUE) ? w_chosen_next : PID_NONE;
            r_d_mode      <= (w_state_next == ST_ISSUE) || (w_state_next == ST_TX_BUSY);
            r_txn_done    <= w_done;
            r_txn_timeout <= w_timeout;
            r_txn_error   <= w_error;
            // A request coinciding with the slot being consumed refills it.
            if (w_slot_release || !r_slot_valid) begin
                r_slot_valid <= ahb_tx_req;
                if (ahb_tx_req) begin
                    r_slot_pid <= pid_t'(ahb_tx_packet);
                end
            end
        end
    end

    assign tx_packet   = r_tx_packet;
    assign d_mode      = r_d_mode;
    assign ahb_tx_busy = r_slot_valid;
    assign txn_done    = r_txn_done;
    assign txn_timeout = r_txn_timeout;
    assign txn_error   = r_txn_error;

endmodule
`default_nettype wire
